// File: rtl/fpu_div_iterative.sv
// FP16 divider: radix-2 restoring mantissa division, one quotient bit per cycle.
// One operation in flight. The result appears 15 cycles after accept, with a one-cycle valid_out pulse.
module fpu_div_iterative #(
    parameter int QBITS = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        ready,
    output logic        valid_out,
    output logic [15:0] result,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        NORM  = 2'd2,
        ROUND = 2'd3
    } state_e;

    state_e             state_q;
    logic               ready_q;
    logic               valid_out_q;
    logic [15:0]        result_q;
    logic               sign_q;
    logic signed [7:0]  exp_q;
    logic [10:0]        mb_q;
    logic [11:0]        rem_q;
    logic [QBITS-1:0]   quo_q;
    logic [3:0]         cnt_q;
    logic               special_q;
    logic [15:0]        special_res_q;
    logic [9:0]         frac_q;

    // Operand unpack and special-case classification.
    logic [4:0]         a_exp, b_exp;
    logic [9:0]         a_frac, b_frac;
    logic               a_zero, a_inf, a_nan;
    logic               b_zero, b_inf, b_nan;
    logic               in_sign;
    logic signed [7:0]  exp_init;
    logic               special_d;
    logic [15:0]        special_res_d;

    always_comb begin
        a_exp    = a[14:10];
        b_exp    = b[14:10];
        a_frac   = a[9:0];
        b_frac   = b[9:0];
        in_sign  = a[15] ^ b[15];
        a_zero   = (a_exp == 5'd0);
        b_zero   = (b_exp == 5'd0);
        a_inf    = (a_exp == 5'd31) && (a_frac == 10'd0);
        b_inf    = (b_exp == 5'd31) && (b_frac == 10'd0);
        a_nan    = (a_exp == 5'd31) && (a_frac != 10'd0);
        b_nan    = (b_exp == 5'd31) && (b_frac != 10'd0);
        exp_init = $signed({3'b000, a_exp}) - $signed({3'b000, b_exp}) + 8'sd15;

        special_d     = 1'b1;
        special_res_d = 16'h0000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            special_res_d = 16'h7E00;
        end else if (a_inf || b_zero) begin
            special_res_d = {in_sign, 15'h7C00};
        end else if (a_zero || b_inf) begin
            special_res_d = {in_sign, 15'h0000};
        end else begin
            special_d = 1'b0;
        end
    end

    // One restoring step. rem_q < 2*mb_q always holds, so the sign bit of the
    // 12-bit difference alone tells whether the divisor fits.
    logic [11:0] rem_diff;
    logic        rem_ge;
    logic [11:0] rem_d;

    always_comb begin
        rem_diff = rem_q - {1'b0, mb_q};
        rem_ge   = ~rem_diff[11];
        rem_d    = rem_ge ? {rem_diff[10:0], 1'b0} : {rem_q[10:0], 1'b0};
    end

    // Normalize to 1.xxx and round to nearest even with guard/round/sticky.
    logic [11:0]        norm_bits;
    logic signed [7:0]  norm_exp;
    logic               sticky;
    logic               round_up;
    logic [10:0]        frac_sum;
    logic [9:0]         rnd_frac;
    logic signed [7:0]  rnd_exp;

    always_comb begin
        norm_bits = quo_q[QBITS-1] ? quo_q[QBITS-2:0] : {quo_q[QBITS-3:0], 1'b0};
        norm_exp  = quo_q[QBITS-1] ? exp_q : (exp_q - 8'sd1);
        sticky    = (rem_q != 12'd0);
        round_up  = norm_bits[1] & (norm_bits[0] | sticky | norm_bits[2]);
        frac_sum  = {1'b0, norm_bits[11:2]} + {10'd0, round_up};
        rnd_frac  = frac_sum[9:0];
        rnd_exp   = frac_sum[10] ? (norm_exp + 8'sd1) : norm_exp;
    end

    logic [15:0] packed_res;

    always_comb begin
        if (special_q) begin
            packed_res = special_res_q;
        end else if (exp_q >= 8'sd31) begin
            packed_res = {sign_q, 15'h7C00};
        end else if (exp_q <= 8'sd0) begin
            packed_res = {sign_q, 15'h0000};
        end else begin
            packed_res = {sign_q, exp_q[4:0], frac_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ready_q       <= 1'b1;
            valid_out_q   <= 1'b0;
            result_q      <= 16'h0000;
            sign_q        <= 1'b0;
            exp_q         <= 8'sd0;
            mb_q          <= 11'd0;
            rem_q         <= 12'd0;
            quo_q         <= '0;
            cnt_q         <= 4'd0;
            special_q     <= 1'b0;
            special_res_q <= 16'h0000;
            frac_q        <= 10'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_out_q <= 1'b0;
                    if (valid_in && ready_q) begin
                        ready_q       <= 1'b0;
                        sign_q        <= in_sign;
                        exp_q         <= exp_init;
                        mb_q          <= {1'b1, b_frac};
                        rem_q         <= {2'b01, a_frac};
                        quo_q         <= '0;
                        cnt_q         <= 4'd0;
                        special_q     <= special_d;
                        special_res_q <= special_res_d;
                        state_q       <= ITER;
                    end
                end
                ITER: begin
                    quo_q <= {quo_q[QBITS-2:0], rem_ge};
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'(QBITS - 1)) begin
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    exp_q   <= rnd_exp;
                    frac_q  <= rnd_frac;
                    state_q <= ROUND;
                end
                ROUND: begin
                    result_q    <= packed_res;
                    valid_out_q <= 1'b1;
                    ready_q     <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready       = ready_q;
    assign valid_out   = valid_out_q;
    assign result      = result_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fpu_div_iterative.sv
// Bench for fpu_div_iterative: directed vector table, handshake/reset sequences,
// and random operands checked against an exact rational reference model.
module tb_fpu_div_iterative;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [15:0] a;
  logic [15:0] b;
  logic        ready;
  logic        valid_out;
  logic [15:0] result;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  fpu_div_iterative #(.QBITS(13)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .a           (a),
    .b           (b),
    .ready       (ready),
    .valid_out   (valid_out),
    .result      (result),
    .dbg_state_o (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: exact quotient of the significands, RNE on the true remainder
  function automatic logic [15:0] ref_div(input logic [15:0] x, input logic [15:0] y);
    logic   s;
    int     ex, ey, fx, fy, e;
    bit     xn, xi, xz, yn, yi, yz;
    longint ma, mb, num, m, r;
    logic [4:0] e5;
    logic [9:0] f10;
    s  = x[15] ^ y[15];
    ex = int'(x[14:10]);
    ey = int'(y[14:10]);
    fx = int'(x[9:0]);
    fy = int'(y[9:0]);
    xn = (ex == 31) && (fx != 0);
    yn = (ey == 31) && (fy != 0);
    xi = (ex == 31) && (fx == 0);
    yi = (ey == 31) && (fy == 0);
    xz = (ex == 0);
    yz = (ey == 0);
    if (xn || yn || (xz && yz) || (xi && yi)) return 16'h7E00;
    if (xi || yz) return {s, 15'h7C00};
    if (xz || yi) return {s, 15'h0000};
    ma = 1024 + fx;
    mb = 1024 + fy;
    e  = ex - ey + 15;
    if (ma >= mb) begin
      num = ma << 10;
    end else begin
      num = ma << 11;
      e   = e - 1;
    end
    m = num / mb;
    r = num % mb;
    if ((2 * r > mb) || ((2 * r == mb) && (m % 2 == 1))) m = m + 1;
    if (m == 2048) begin
      m = 1024;
      e = e + 1;
    end
    if (e >= 31) return {s, 15'h7C00};
    if (e <= 0) return {s, 15'h0000};
    e5  = 5'(e);
    f10 = 10'(m - 1024);
    return {s, e5, f10};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // driver: waits for ready, pulses valid_in for one cycle, queues the model result
  task automatic send(input logic [15:0] ta, input logic [15:0] tb_v, input logic [15:0] want);
    int n;
    n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_wait_ready", 0, 1);
    a        = ta;
    b        = tb_v;
    valid_in = 1'b1;
    exp_q.push_back(want);
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  // scoreboard: waits for valid_out, checks latency, busy ready and result
  task automatic wait_result(input string name, input int start);
    int          n;
    bit          busy_ok;
    logic [15:0] want;
    n       = start;
    busy_ok = 1'b1;
    while (!valid_out && n < 60) begin
      if (ready) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    check({name, "_latency"}, n, 15);
    check({name, "_busy"}, busy_ok, 1);
    if (valid_out) begin
      check({name, "_ready_at_done"}, ready, 1);
      check(name, result, want);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
  } vec_t;

  function automatic logic [15:0] rand_fp();
    logic [15:0] pool[8];
    logic [31:0] r;
    pool[0] = 16'h0000; pool[1] = 16'h8000; pool[2] = 16'h7C00; pool[3] = 16'hFC00;
    pool[4] = 16'h7E00; pool[5] = 16'h7D01; pool[6] = 16'h0001; pool[7] = 16'h83FF;
    r = $urandom;
    if ($urandom_range(0, 7) == 0) return pool[$urandom_range(0, 7)];
    return r[15:0];
  endfunction

  initial begin
    vec_t        vecs[15];
    logic [15:0] ra, rb, last, want;
    int          n, pulses, quiet;
    bit          pos_ok, hold_ok, val_ok;

    vecs[0]  = '{16'h4600, 16'h4000, 16'h4200};
    vecs[1]  = '{16'hC600, 16'h4000, 16'hC200};
    vecs[2]  = '{16'h3C00, 16'h4200, 16'h3555};
    vecs[3]  = '{16'h3C00, 16'h3C00, 16'h3C00};
    vecs[4]  = '{16'h3C00, 16'h0000, 16'h7C00};
    vecs[5]  = '{16'hBC00, 16'h0000, 16'hFC00};
    vecs[6]  = '{16'h0000, 16'h0000, 16'h7E00};
    vecs[7]  = '{16'h7C00, 16'h7C00, 16'h7E00};
    vecs[8]  = '{16'h4000, 16'h7C00, 16'h0000};
    vecs[9]  = '{16'h7BFF, 16'h3800, 16'h7C00};
    vecs[10] = '{16'h0400, 16'h4000, 16'h0000};
    vecs[11] = '{16'h0001, 16'h3C00, 16'h0000};
    vecs[12] = '{16'h7E01, 16'h3C00, 16'h7E00};
    vecs[13] = '{16'hFC00, 16'h4000, 16'hFC00};
    vecs[14] = '{16'h0000, 16'hC000, 16'h8000};

    // reset
    rst_n    = 1'b0;
    valid_in = 1'b0;
    a        = 16'h0000;
    b        = 16'h0000;
    repeat (3) @(negedge clk);
    check("reset_ready", ready, 1);
    check("reset_valid_out", valid_out, 0);
    check("reset_result", result, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // directed vector table
    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].res);
      wait_result($sformatf("vec%0d", i), 0);
    end

    // valid_out is a single-cycle pulse and the result holds afterwards
    @(negedge clk);
    check("pulse_width", valid_out, 0);
    check("result_hold", result, vecs[14].res);

    // valid_in while busy is ignored
    send(16'h4600, 16'h4000, 16'h4200);
    repeat (4) @(negedge clk);
    a        = 16'h7BFF;
    b        = 16'h3800;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    wait_result("busy_ignore", 5);
    quiet = 0;
    val_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (valid_out) quiet++;
      if (!ready) val_ok = 1'b0;
    end
    check("busy_ignore_no_extra", quiet, 0);
    check("busy_ignore_idle", val_ok, 1);

    // valid_in held high: accept in every valid_out cycle
    want     = ref_div(16'h3C00, 16'h4200);
    a        = 16'h3C00;
    b        = 16'h4200;
    valid_in = 1'b1;
    @(negedge clk);
    n       = 0;
    pulses  = 0;
    pos_ok  = 1'b1;
    hold_ok = 1'b1;
    val_ok  = 1'b1;
    last    = 16'h0000;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (valid_out) begin
        pulses++;
        if (n != 16 * pulses - 1) pos_ok = 1'b0;
        if (!ready) pos_ok = 1'b0;
        if (result !== want) val_ok = 1'b0;
        last = result;
      end else if (pulses > 0 && result !== last) begin
        hold_ok = 1'b0;
      end
    end
    valid_in = 1'b0;
    exp_q.push_back(want);
    check("held_pulse_count", pulses, 3);
    check("held_pulse_spacing", pos_ok, 1);
    check("held_results", val_ok, 1);
    check("held_result_hold", hold_ok, 1);
    wait_result("held_last", 2);

    // reset in the middle of an operation
    @(negedge clk);
    send(16'h4600, 16'h4000, 16'h4200);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_ready", ready, 1);
    check("midreset_valid_out", valid_out, 0);
    check("midreset_result", result, 16'h0000);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid_out) quiet++;
    end
    check("midreset_no_valid_out", quiet, 0);
    send(16'hC600, 16'h4000, 16'hC200);
    wait_result("after_reset", 0);

    // random operands against the reference model
    for (int i = 0; i < 300; i++) begin
      ra = rand_fp();
      rb = rand_fp();
      send(ra, rb, ref_div(ra, rb));
      wait_result($sformatf("rand%0d_%h_%h", i, ra, rb), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
